// File: rtl/receptor_pkg.sv
// Shared types and constants for the serial frame receiver feeding the Display stage.
package receptor_pkg;

    typedef enum logic [2:0] {
        OCIOSO,
        INICIO,
        DADOS,
        PAR,
        PARADA
    } estado_t;

    localparam int   N_DADOS      = 5;
    localparam logic LINHA_OCIOSA = 1'b1;
    localparam int   IDX_W        = $clog2(N_DADOS);

endpackage

// File: rtl/receptor_serial_sincronizador.sv
// Two-flop synchronizer for the serial line; both flops reset to the idle line level.
module sincronizador
    import receptor_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ff_q <= {2{LINHA_OCIOSA}};
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/receptor_serial.sv
// Serial frame receiver: start, 5 data bits LSB-first, parity, stop; holds the last good frame.
// Optional input synchronizer enabled by defining RECEPTOR_SINCRONIZADOR_EN.
module receptor_serial
    import receptor_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Linha,
    output logic [4:0] Valores,
    output logic       Paridade,
    output logic       Pronto,
    output logic       ErroQuadro
);

    localparam int                CW         = $clog2(DIVISOR);
    localparam logic [CW-1:0]     CNT_MEIO   = CW'(DIVISOR / 2 - 1);
    localparam logic [CW-1:0]     CNT_ULTIMO = CW'(DIVISOR - 1);
    localparam logic [IDX_W-1:0]  IDX_ULTIMO = IDX_W'(N_DADOS - 1);

    if (DIVISOR < 4 || (DIVISOR % 2) != 0) begin : g_divisor_invalido
        $error("receptor_serial: DIVISOR must be even and >= 4");
    end

    logic s;

`ifdef RECEPTOR_SINCRONIZADOR_EN
    sincronizador u_sincronizador (
        .clk_i (Clock),
        .rst_i (Reset),
        .d_i   (Linha),
        .q_o   (s)
    );
`else
    assign s = Linha;
`endif

    estado_t              estado_q;
    logic [CW-1:0]        cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 s_ant_q;
    logic [N_DADOS-1:0]   sombra_q;
    logic                 par_sombra_q;
    logic [N_DADOS-1:0]   valores_q;
    logic                 paridade_q;
    logic                 pronto_q;
    logic                 erro_q;
    logic                 fim_bit;

    assign fim_bit = (cnt_q == CNT_ULTIMO);

    // Shadow registers collect the frame; the outputs load only on a good stop bit.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            estado_q     <= OCIOSO;
            cnt_q        <= '0;
            idx_q        <= '0;
            s_ant_q      <= LINHA_OCIOSA;
            sombra_q     <= '0;
            par_sombra_q <= 1'b0;
            valores_q    <= '0;
            paridade_q   <= 1'b0;
            pronto_q     <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            s_ant_q  <= s;
            pronto_q <= 1'b0;
            erro_q   <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (s_ant_q == LINHA_OCIOSA && s != LINHA_OCIOSA) begin
                        cnt_q    <= '0;
                        estado_q <= INICIO;
                    end
                end
                INICIO: begin
                    if (cnt_q == CNT_MEIO) begin
                        cnt_q <= '0;
                        if (s == LINHA_OCIOSA) begin
                            estado_q <= OCIOSO;
                        end else begin
                            idx_q    <= '0;
                            estado_q <= DADOS;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DADOS: begin
                    if (fim_bit) begin
                        cnt_q           <= '0;
                        sombra_q[idx_q] <= s;
                        if (idx_q == IDX_ULTIMO) begin
                            estado_q <= PAR;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PAR: begin
                    if (fim_bit) begin
                        cnt_q        <= '0;
                        par_sombra_q <= s;
                        estado_q     <= PARADA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PARADA: begin
                    if (fim_bit) begin
                        cnt_q    <= '0;
                        estado_q <= OCIOSO;
                        if (s == LINHA_OCIOSA) begin
                            valores_q  <= sombra_q;
                            paridade_q <= par_sombra_q;
                            pronto_q   <= 1'b1;
                        end else begin
                            erro_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_q    <= '0;
                    estado_q <= OCIOSO;
                end
            endcase
        end
    end

    assign Valores    = valores_q;
    assign Paridade   = paridade_q;
    assign Pronto     = pronto_q;
    assign ErroQuadro = erro_q;

endmodule

// File: tb/tb_receptor_serial.sv
// Bench for receptor_serial: frame-level model of the last good frame and strobe timing.
module tb_receptor_serial;

    localparam int D = 16;
`ifdef RECEPTOR_SINCRONIZADOR_EN
    localparam int SINC = 2;
`else
    localparam int SINC = 0;
`endif
    // From the cycle the line falls to the cycle the strobe is visible.
    localparam int LAT = 1 + D / 2 + 7 * D + SINC;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Linha;
    logic [4:0] Valores;
    logic       Paridade;
    logic       Pronto;
    logic       ErroQuadro;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int         cyc;
        logic       pronto;
        logic [5:0] saida;
    } evento_t;

    evento_t    ev_q[$];
    logic [5:0] exp_q[$];
    logic       exp_pronto_q[$];
    logic [5:0] ref_saida;

    receptor_serial #(.DIVISOR(D)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Linha      (Linha),
        .Valores    (Valores),
        .Paridade   (Paridade),
        .Pronto     (Pronto),
        .ErroQuadro (ErroQuadro)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    always @(negedge Clock) begin
        if (Pronto || ErroQuadro) begin
            evento_t e;
            e.cyc    = cyc;
            e.pronto = Pronto;
            e.saida  = {Paridade, Valores};
            ev_q.push_back(e);
            n_checks++;
            if (Pronto && ErroQuadro) begin
                n_fail++;
                $display("FAIL strobe_exclusive: Pronto=%b ErroQuadro=%b at cycle %0d, required not both 1",
                         Pronto, ErroQuadro, cyc);
            end
        end
    end

    task automatic ciclos(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic ocioso(input int n);
        Linha = 1'b1;
        ciclos(n);
    endtask

    task automatic limpar();
        ev_q.delete();
        exp_q.delete();
        exp_pronto_q.delete();
    endtask

    // Drives one complete frame and records what the receiver must report for it.
    task automatic enviar_quadro(input logic [4:0] d, input logic p, input logic stop, output int n0);
        logic [7:0] bits;
        bits = {stop, p, d, 1'b0};
        n0 = cyc;
        for (int i = 0; i < 8; i++) begin
            Linha = bits[i];
            ciclos(D);
        end
        if (stop) ref_saida = {p, d};
        exp_pronto_q.push_back(stop);
        exp_q.push_back(ref_saida);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Linha = 1'b1;
        ref_saida = 6'b0;
        ciclos(3);
        @(negedge Clock);
        n_checks++;
        if (Valores !== 5'b0) begin n_fail++; $display("FAIL reset_valores: got %b need 00000", Valores); end
        n_checks++;
        if (Paridade !== 1'b0) begin n_fail++; $display("FAIL reset_paridade: got %b need 0", Paridade); end
        n_checks++;
        if (Pronto !== 1'b0) begin n_fail++; $display("FAIL reset_pronto: got %b need 0", Pronto); end
        n_checks++;
        if (ErroQuadro !== 1'b0) begin n_fail++; $display("FAIL reset_erro: got %b need 0", ErroQuadro); end
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        ocioso(D);
    endtask

    task automatic test_quadro_simples();
        int n0;
        limpar();
        enviar_quadro(5'b00001, 1'b1, 1'b1, n0);
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== 1) begin
            n_fail++;
            $display("FAIL simples_eventos: got %0d strobes need 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].pronto !== 1'b1) begin n_fail++; $display("FAIL simples_pronto: got %b need 1", ev_q[0].pronto); end
            n_checks++;
            if (ev_q[0].saida !== 6'b100001) begin n_fail++; $display("FAIL simples_saida: got %b need 100001", ev_q[0].saida); end
            n_checks++;
            if (ev_q[0].cyc !== n0 + LAT) begin n_fail++; $display("FAIL simples_latencia: got %0d need %0d", ev_q[0].cyc, n0 + LAT); end
        end
        n_checks++;
        if ({Paridade, Valores} !== 6'b100001) begin
            n_fail++;
            $display("FAIL simples_retido: got %b need 100001", {Paridade, Valores});
        end
    endtask

    task automatic test_back_to_back();
        int n0;
        int n0_primeiro;
        limpar();
        enviar_quadro(5'b00000, 1'b0, 1'b1, n0_primeiro);
        enviar_quadro(5'b00010, 1'b0, 1'b1, n0);
        enviar_quadro(5'b00100, 1'b1, 1'b1, n0);
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== 3) begin
            n_fail++;
            $display("FAIL b2b_eventos: got %0d strobes need 3", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].cyc !== n0_primeiro + LAT) begin
                n_fail++;
                $display("FAIL b2b_latencia: got %0d need %0d", ev_q[0].cyc, n0_primeiro + LAT);
            end
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (ev_q[i].pronto !== 1'b1 || ev_q[i].saida !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_quadro%0d: got pronto=%b saida=%b need pronto=1 saida=%b",
                             i, ev_q[i].pronto, ev_q[i].saida, exp_q[i]);
                end
                if (i > 0) begin
                    n_checks++;
                    if (ev_q[i].cyc - ev_q[i-1].cyc !== 8 * D) begin
                        n_fail++;
                        $display("FAIL b2b_intervalo%0d: got %0d need %0d", i, ev_q[i].cyc - ev_q[i-1].cyc, 8 * D);
                    end
                end
            end
        end
    endtask

    task automatic test_erro_quadro();
        int n0;
        logic [5:0] antes;
        limpar();
        antes = ref_saida;
        enviar_quadro(5'b10101, 1'b1, 1'b0, n0);
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== 1) begin
            n_fail++;
            $display("FAIL erro_eventos: got %0d strobes need 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].pronto !== 1'b0) begin n_fail++; $display("FAIL erro_tipo: got pronto=%b need 0", ev_q[0].pronto); end
            n_checks++;
            if (ev_q[0].cyc !== n0 + LAT) begin n_fail++; $display("FAIL erro_latencia: got %0d need %0d", ev_q[0].cyc, n0 + LAT); end
        end
        n_checks++;
        if ({Paridade, Valores} !== antes) begin
            n_fail++;
            $display("FAIL erro_retido: got %b need %b", {Paridade, Valores}, antes);
        end
    endtask

    task automatic test_glitch();
        limpar();
        Linha = 1'b0;
        ciclos(4);
        ocioso(3 * D);
        n_checks++;
        if (ev_q.size() !== 0) begin n_fail++; $display("FAIL glitch_eventos: got %0d strobes need 0", ev_q.size()); end
        n_checks++;
        if ({Paridade, Valores} !== ref_saida) begin
            n_fail++;
            $display("FAIL glitch_retido: got %b need %b", {Paridade, Valores}, ref_saida);
        end
    endtask

    task automatic test_linha_baixa();
        int n0;
        limpar();
        enviar_quadro(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, n0);
        Linha = 1'b0;
        ciclos(20 * D);
        n_checks++;
        if (ev_q.size() !== 1 || ev_q[0].pronto !== 1'b0) begin
            n_fail++;
            $display("FAIL baixa_sem_quadros: got %0d strobes need exactly 1 framing error", ev_q.size());
        end
        ocioso(D);
        enviar_quadro(5'($urandom_range(1, 31)), 1'($urandom_range(0, 1)), 1'b1, n0);
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== 2) begin
            n_fail++;
            $display("FAIL baixa_retorno: got %0d strobes need 2", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[1].pronto !== 1'b1 || ev_q[1].saida !== exp_q[1]) begin
                n_fail++;
                $display("FAIL baixa_quadro: got pronto=%b saida=%b need pronto=1 saida=%b",
                         ev_q[1].pronto, ev_q[1].saida, exp_q[1]);
            end
        end
    endtask

    task automatic test_reset_meio();
        int n0;
        logic [7:0] bits;
        limpar();
        bits = {1'b1, 1'b1, 5'($urandom_range(0, 31)), 1'b0};
        for (int i = 0; i < 4; i++) begin
            Linha = bits[i];
            ciclos(D);
        end
        Linha = bits[4];
        ciclos(D / 2);
        Reset = 1'b1;
        Linha = 1'b1;
        ref_saida = 6'b0;
        @(negedge Clock);
        n_checks++;
        if ({Paridade, Valores, Pronto, ErroQuadro} !== 8'b0) begin
            n_fail++;
            $display("FAIL reset_meio_saidas: got P=%b V=%b Pr=%b E=%b need all 0", Paridade, Valores, Pronto, ErroQuadro);
        end
        ciclos(3);
        Reset = 1'b0;
        ocioso(D);
        n_checks++;
        if (ev_q.size() !== 0) begin n_fail++; $display("FAIL reset_meio_abortado: got %0d strobes need 0", ev_q.size()); end
        enviar_quadro(5'b11111, 1'b1, 1'b1, n0);
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== 1) begin
            n_fail++;
            $display("FAIL reset_meio_eventos: got %0d strobes need 1", ev_q.size());
        end else begin
            n_checks++;
            if (ev_q[0].pronto !== 1'b1 || ev_q[0].saida !== 6'b111111) begin
                n_fail++;
                $display("FAIL reset_meio_quadro: got pronto=%b saida=%b need pronto=1 saida=111111", ev_q[0].pronto, ev_q[0].saida);
            end
        end
    endtask

    task automatic test_aleatorio();
        int n0;
        int gap;
        logic stop;
        logic stop_ant;
        limpar();
        stop_ant = 1'b1;
        for (int k = 0; k < 24; k++) begin
            gap = stop_ant ? $urandom_range(0, D) : $urandom_range(1, D);
            if (gap > 0) ocioso(gap);
            stop = ($urandom_range(0, 3) != 0);
            enviar_quadro(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), stop, n0);
            stop_ant = stop;
        end
        ocioso(2 * D);
        n_checks++;
        if (ev_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL aleatorio_eventos: got %0d strobes need %0d", ev_q.size(), exp_q.size());
        end
        for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (ev_q[i].pronto !== exp_pronto_q[i] || ev_q[i].saida !== exp_q[i]) begin
                n_fail++;
                $display("FAIL aleatorio_quadro%0d: got pronto=%b saida=%b need pronto=%b saida=%b",
                         i, ev_q[i].pronto, ev_q[i].saida, exp_pronto_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        Reset = 1'b1;
        Linha = 1'b1;
        ref_saida = 6'b0;
        test_reset();
        test_quadro_simples();
        test_back_to_back();
        test_erro_quadro();
        test_glitch();
        test_linha_baixa();
        test_reset_meio();
        test_aleatorio();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
